// File: rtl/usrt_tx_if.sv
// Write-side bus of the USRT transmitter: byte strobe in, FIFO status out.
interface usrt_tx_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          wEn;
  logic [7:0]    pWData;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          ovf;

  modport master (
    output wEn, pWData,
    input  full, empty, level, ovf
  );

  modport slave (
    input  wEn, pWData,
    output full, empty, level, ovf
  );
endinterface

// File: rtl/usrt_tx.sv
// USRT transmit stage: byte FIFO feeding an 11-bit frame serializer
// (start=1, d[0..7], even parity, stop=0), one bit per baud tick.
module usrt_tx #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       pClk,
  input  logic       uRst,
  input  logic       uTick,
  output logic       Rx,
  output logic       busy,
  usrt_tx_if.slave   wr
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] occ;
  logic          fifo_empty;
  logic          fifo_full;
  logic [7:0]    head;
  logic          push;
  logic          pop;
  logic          drop;
  logic          ovf_q;

  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [2:0]    bc;
  logic [2:0]    bc_nx;
  logic [7:0]    sh;
  logic [7:0]    sh_nx;
  logic          par;
  logic          par_nx;
  logic          rx_nx;

  // FIFO status decoded from the wide pointers
  assign occ        = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (occ == PW'(DEPTH));
  assign head       = mem[rd_ptr[AW-1:0]];

  // A pop frees the head slot in the same cycle, so a write into a full FIFO is still taken
  assign push = wr.wEn && (!fifo_full || pop);
  assign drop = wr.wEn && fifo_full && !pop;

  assign wr.full  = fifo_full;
  assign wr.empty = fifo_empty;
  assign wr.level = occ;
  assign wr.ovf   = ovf_q;
  assign busy     = (state != S_IDLE);

  // Next-state, next-bit and pop decision; nothing moves without a baud tick
  always_comb begin
    state_nx = state;
    bc_nx    = bc;
    sh_nx    = sh;
    par_nx   = par;
    rx_nx    = Rx;
    pop      = 1'b0;
    if (uTick) begin
      case (state)
        S_IDLE, S_STOP: begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            sh_nx    = head;
            par_nx   = ^head;
            rx_nx    = 1'b1;
            state_nx = S_START;
          end else begin
            rx_nx    = 1'b0;
            state_nx = S_IDLE;
          end
        end
        S_START: begin
          rx_nx    = sh[0];
          bc_nx    = 3'd0;
          state_nx = S_DATA;
        end
        S_DATA: begin
          if (bc != 3'd7) begin
            rx_nx = sh[3'(bc + 3'd1)];
            bc_nx = 3'(bc + 3'd1);
          end else begin
            rx_nx    = par;
            state_nx = S_PARITY;
          end
        end
        S_PARITY: begin
          rx_nx    = 1'b0;
          state_nx = S_STOP;
        end
        default: begin
          rx_nx    = 1'b0;
          state_nx = S_IDLE;
        end
      endcase
    end
  end

  // FSM, line, pointer and overflow registers
  always_ff @(posedge pClk) begin
    if (uRst) begin
      state  <= S_IDLE;
      bc     <= 3'd0;
      sh     <= 8'd0;
      par    <= 1'b0;
      Rx     <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else begin
      state <= state_nx;
      bc    <= bc_nx;
      sh    <= sh_nx;
      par   <= par_nx;
      Rx    <= rx_nx;
      if (push) wr_ptr <= PW'(wr_ptr + PW'(1));
      if (pop)  rd_ptr <= PW'(rd_ptr + PW'(1));
      if (drop) ovf_q  <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge pClk) begin
    if (!uRst && push) mem[wr_ptr[AW-1:0]] <= wr.pWData;
  end
endmodule

// File: tb/tb_usrt_tx.sv
// Self-checking bench for usrt_tx: queue-based transmitter model plus a
// line monitor that deserializes frames and checks them against a scoreboard.
module tb_usrt_tx;
  localparam int unsigned DEPTH = 4;

  logic pClk = 1'b0;
  logic uRst;
  logic uTick;
  logic Rx;
  logic busy;

  usrt_tx_if #(.DEPTH(DEPTH)) wr();

  usrt_tx #(.DEPTH(DEPTH)) dut (
    .pClk  (pClk),
    .uRst  (uRst),
    .uTick (uTick),
    .Rx    (Rx),
    .busy  (busy),
    .wr    (wr)
  );

  always #5 pClk = ~pClk;

  int total = 0;
  int bad   = 0;

  // Model: bytes waiting in the FIFO, ticks left before the line is free again
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  int         ticks_left = 0;
  bit         active = 0;
  bit         ovf_m = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, compare status flags after the edge
  task automatic step(input bit we, input logic [7:0] d, input bit tk, input bit rst);
    bit pop_m;
    @(negedge pClk);
    wr.wEn = we; wr.pWData = d; uTick = tk; uRst = rst;
    if (rst) begin
      mq.delete(); exp_q.delete();
      ticks_left = 0; active = 0; ovf_m = 0;
    end else begin
      pop_m = tk && (ticks_left == 0) && (mq.size() > 0);
      if (we) begin
        if (mq.size() < DEPTH || pop_m) begin
          mq.push_back(d);
          exp_q.push_back(d);
        end else begin
          ovf_m = 1;
        end
      end
      if (pop_m) begin
        void'(mq.pop_front());
        ticks_left = 10;
        active = 1;
      end else if (tk) begin
        if (ticks_left > 0) ticks_left--;
        else active = 0;
      end
    end
    @(posedge pClk); #1;
    chk("level", int'(wr.level), mq.size());
    chk("full",  int'(wr.full),  int'(mq.size() == DEPTH));
    chk("empty", int'(wr.empty), int'(mq.size() == 0));
    chk("ovf",   int'(wr.ovf),   int'(ovf_m));
    chk("busy",  int'(busy),     int'(active));
  endtask

  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) step(0, 8'h00, 0, 0);
      step(0, 8'h00, 1, 0);
    end
  endtask

  task automatic wr_byte(input logic [7:0] d);
    step(1, d, 0, 0);
  endtask

  // Line monitor: deserializes frames on tick edges and pops the scoreboard
  bit         in_frame = 0;
  int         nb = 0;
  logic [9:0] bits;
  logic       rx_prev = 1'b0;

  always @(posedge pClk) begin
    logic       tk_s;
    logic       rs_s;
    logic [7:0] got;
    logic [7:0] want;
    tk_s = uTick;
    rs_s = uRst;
    #1;
    if (rs_s) begin
      in_frame = 0;
      nb = 0;
      chk("rx_reset", int'(Rx), 0);
    end else if (!tk_s) begin
      chk("rx_hold", int'(Rx), int'(rx_prev));
    end else if (!in_frame) begin
      if (Rx) begin
        in_frame = 1;
        nb = 0;
      end
    end else begin
      bits[nb] = Rx;
      nb++;
      if (nb == 10) begin
        in_frame = 0;
        got = bits[7:0];
        chk("parity", int'(bits[8]), int'(^got));
        chk("stop",   int'(bits[9]), 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got %02h expected none at %0t", got, $time);
        end else begin
          want = exp_q.pop_front();
          chk("frame_byte", int'(got), int'(want));
        end
      end
    end
    rx_prev = Rx;
  end

  initial begin
    wr.wEn = 0; wr.pWData = 0; uTick = 0; uRst = 1;
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 1, 1);
    chk("rx_after_reset", int'(Rx), 0);

    // 0xA5 written on a tick cycle: that tick must not start the frame
    step(1, 8'hA5, 1, 0);
    ticks(14, 2);

    // parity=1 byte and all-zero byte
    wr_byte(8'h01);
    wr_byte(8'h00);
    ticks(30, 1);

    // overflow: fill with no ticks, fifth write dropped, then drain in order
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) wr_byte(8'(8'h10 + i));
    ticks(60, 0);

    // back-to-back frames with consecutive ticks
    step(0, 8'h00, 0, 1);
    wr_byte(8'h3C);
    wr_byte(8'hC3);
    ticks(26, 0);

    // reset in the middle of the data bits with a second byte queued
    wr_byte(8'hA1);
    wr_byte(8'hB2);
    ticks(6, 1);
    step(0, 8'h00, 0, 1);
    chk("abort_rx", int'(Rx), 0);
    ticks(30, 1);

    // write into a full FIFO on the STOP tick: pop and push both happen
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) wr_byte(8'(8'h20 + i));
    ticks(1, 0);
    wr_byte(8'h55);
    ticks(10, 0);
    step(1, 8'h77, 1, 0);
    chk("full_swap_level", int'(wr.level), DEPTH);
    ticks(70, 0);

    // randomized traffic with varied tick spacing
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 4000; i++) begin
      bit we;
      bit tk;
      we = ($urandom_range(0, 99) < 8);
      tk = (i % 1000 < 200) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
      step(we, 8'($urandom), tk, 0);
    end
    ticks(70, 0);

    chk("frames_pending", exp_q.size(), 0);
    chk("final_busy", int'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
